sata_link_tx_framer: RTL
========================

SATA_LINK_TX_FRAMER -- requirements
Module: sata_link_tx_framer

Interface
REQ-001 Parameter WTRM_TIMEOUT, default 65535, is the maximum WTRM cycles awaiting R_OK/R_ERR (16-bit, >=1).
REQ-002 Ports, one per line: name, direction, width, meaning; clock and reset first.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 fifo_data  in  32  scrambled TX dword, valid while fifo_empty low (show-ahead FIFO).
REQ-006 fifo_eop  in  1  marks last dword of frame (CRC dword).
REQ-007 fifo_rdreq  out  1  pops current FIFO word.
REQ-008 fifo_empty  in  1  FIFO empty.
REQ-009 fifo_almostempty  in  1  FIFO almost empty (unused for flow control; ignored).
REQ-010 phy_rdy  in  1  PHY link established.
REQ-011 rx_r_rdy, rx_r_ok, rx_r_err, rx_hold, rx_sync  in  1 each  decoded received primitives, level while received.
REQ-012 link_dat  out  32  dword to PHY.
REQ-013 link_isk  out  1  link_dat is a primitive (K28.x in byte 0).
REQ-014 tx_busy  out  1  frame in progress (state not IDLE).
REQ-015 tx_ok, tx_err  out  1 each  one-cycle frame completion status pulses.

Function
REQ-016 Primitive codes SHALL be: SYNC 0xB5B5957C, X_RDY 0x5757B57C, SOF 0x3737B57C, EOF 0xD5D5B57C, HOLD 0xD5D5AA7C, HOLDA 0x9595AA7C, WTRM 0x5858B57C; all with link_isk=1, data dwords link_isk=0.
REQ-017 link_dat/link_isk SHALL be registered: the word for state/pop of cycle N appears at cycle N+1.
REQ-018 States: IDLE, XRDY, SOF, DATA, HOLD, HOLDA, EOF, WTRM, DRAIN.
REQ-019 IDLE: send SYNC; phy_rdy=1 and fifo_empty=0 -> XRDY.
REQ-020 XRDY: send X_RDY; rx_r_rdy=1 -> SOF.
REQ-021 SOF: send SOF for exactly one cycle -> DATA.
REQ-022 DATA: fifo_rdreq = ~fifo_empty & ~rx_hold & phy_rdy; popped dword sent; popped with fifo_eop=1 -> EOF.
REQ-023 DATA with rx_hold=1 -> HOLDA (send HOLDA, no pop) until rx_hold=0, then DATA; rx_hold takes priority over fifo_empty.
REQ-024 DATA with fifo_empty=1, rx_hold=0 -> HOLD (send HOLD) until fifo_empty=0, then DATA; rx_hold=1 in HOLD -> HOLDA.
REQ-025 EOF: send EOF one cycle -> WTRM.
REQ-026 WTRM: send WTRM; rx_r_ok -> IDLE with tx_ok pulse; rx_r_err or rx_sync -> IDLE with tx_err pulse; rx_r_err wins over rx_r_ok if simultaneous.
REQ-027 phy_rdy=0 in any non-IDLE state: tx_err pulse (not in WTRM after ok/err already resolved); if eop dword not yet popped -> DRAIN, else -> IDLE.
REQ-028 DRAIN: send SYNC; fifo_rdreq=~fifo_empty; discard until eop dword popped -> IDLE.
REQ-029 rx_sync in XRDY/SOF/DATA/HOLD/HOLDA SHALL abort as REQ-027 with tx_err pulse.
REQ-030 fifo_rdreq SHALL never assert while fifo_empty=1.

Reset
REQ-031 reset=0 at a clock edge: state IDLE, link_dat=SYNC, link_isk=1, fifo_rdreq=0, tx_busy=0, tx_ok=0, tx_err=0, timeout counter 0; reset mid-frame discards frame, no status pulse.

Configuration
REQ-032 Macro SATA_LINK_TX_FRAMER_TIMEOUT_EN defined: 16-bit counter clears on WTRM entry, increments each WTRM cycle; reaching WTRM_TIMEOUT -> IDLE with tx_err pulse.
REQ-033 Macro undefined: no counter; WTRM waits indefinitely for rx_r_ok/rx_r_err/rx_sync/phy_rdy=0.

Verification
REQ-034 FIFO holds 3 dwords (0x11111111,0x22222222,0x33333333 eop), rx_r_rdy after 4 cycles, rx_r_ok in WTRM -> link stream X_RDY..SOF,11111111,22222222,33333333,EOF,WTRM..,SYNC; tx_ok one pulse.
REQ-035 rx_hold asserted 3 cycles after second data dword -> exactly 3 HOLDA dwords, no pops, then resume with third dword.
REQ-036 FIFO empties after first dword for 5 cycles -> 5 HOLD dwords, then remaining dwords, no dword lost/duplicated.
REQ-037 rx_r_err and rx_r_ok same cycle in WTRM -> tx_err=1, tx_ok=0.
REQ-038 phy_rdy dropped after 2nd of 10 dwords -> tx_err pulse, DRAIN pops remaining 8 including eop, SYNC output, IDLE.
REQ-039 With SATA_LINK_TX_FRAMER_TIMEOUT_EN, WTRM_TIMEOUT=16, no response -> 16 WTRM dwords, then tx_err and SYNC.

Source files
------------

// File: rtl/sata_link_tx_framer.sv
// SATA link-layer transmit framer: X_RDY/SOF handshake, data with HOLD/HOLDA flow control, EOF/WTRM status.
// Define SATA_LINK_TX_FRAMER_TIMEOUT_EN to bound the WTRM wait by WTRM_TIMEOUT cycles.
//
// state | meaning
// IDLE  | send SYNC, wait for phy_rdy and a queued frame
// XRDY  | send X_RDY until the far end answers R_RDY
// SOF   | send SOF for one cycle
// DATA  | pop and send frame dwords
// HOLD  | FIFO starved, send HOLD
// HOLDA | far end holding, send HOLDA
// EOF   | send EOF for one cycle
// WTRM  | send WTRM until R_OK / R_ERR / SYNC
// DRAIN | aborted frame, discard dwords up to eop while sending SYNC
module sata_link_tx_framer #(
  parameter int WTRM_TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] fifo_data,
  input  logic        fifo_eop,
  output logic        fifo_rdreq,
  input  logic        fifo_empty,
  input  logic        fifo_almostempty,
  input  logic        phy_rdy,
  input  logic        rx_r_rdy,
  input  logic        rx_r_ok,
  input  logic        rx_r_err,
  input  logic        rx_hold,
  input  logic        rx_sync,
  output logic [31:0] link_dat,
  output logic        link_isk,
  output logic        tx_busy,
  output logic        tx_ok,
  output logic        tx_err
);

  localparam logic [31:0] P_SYNC  = 32'hB5B5_957C;
  localparam logic [31:0] P_X_RDY = 32'h5757_B57C;
  localparam logic [31:0] P_SOF   = 32'h3737_B57C;
  localparam logic [31:0] P_EOF   = 32'hD5D5_B57C;
  localparam logic [31:0] P_HOLD  = 32'hD5D5_AA7C;
  localparam logic [31:0] P_HOLDA = 32'h9595_AA7C;
  localparam logic [31:0] P_WTRM  = 32'h5858_B57C;

  if (WTRM_TIMEOUT < 1 || WTRM_TIMEOUT > 65535) begin : g_bad_timeout
    $error("WTRM_TIMEOUT must be within 1..65535");
  end

  typedef enum logic [3:0] {
    S_IDLE, S_XRDY, S_SOF, S_DATA, S_HOLD, S_HOLDA, S_EOF, S_WTRM, S_DRAIN
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [31:0] dat_d;
  logic        isk_d;
  logic        ok_d;
  logic        err_d;
  logic        rdreq;
  logic        abort_link;
  logic        wtrm_timeout;
  logic        unused_almostempty;

  assign unused_almostempty = fifo_almostempty;
  assign abort_link = ~phy_rdy | rx_sync;

  always_comb begin
    next_state = state;
    dat_d      = P_SYNC;
    isk_d      = 1'b1;
    ok_d       = 1'b0;
    err_d      = 1'b0;
    rdreq      = 1'b0;
    case (state)
      S_IDLE: begin
        if (phy_rdy && !fifo_empty) next_state = S_XRDY;
      end
      S_XRDY: begin
        if (abort_link) begin
          err_d      = 1'b1;
          next_state = S_DRAIN;
        end else begin
          dat_d = P_X_RDY;
          if (rx_r_rdy) next_state = S_SOF;
        end
      end
      S_SOF: begin
        if (abort_link) begin
          err_d      = 1'b1;
          next_state = S_DRAIN;
        end else begin
          dat_d      = P_SOF;
          next_state = S_DATA;
        end
      end
      // The three payload states share one decision so every stall cycle emits exactly one HOLD/HOLDA.
      S_DATA, S_HOLD, S_HOLDA: begin
        if (abort_link) begin
          err_d      = 1'b1;
          next_state = S_DRAIN;
        end else if (rx_hold) begin
          dat_d      = P_HOLDA;
          next_state = S_HOLDA;
        end else if (fifo_empty) begin
          dat_d      = P_HOLD;
          next_state = S_HOLD;
        end else begin
          rdreq      = 1'b1;
          dat_d      = fifo_data;
          isk_d      = 1'b0;
          next_state = fifo_eop ? S_EOF : S_DATA;
        end
      end
      S_EOF: begin
        if (!phy_rdy) begin
          err_d      = 1'b1;
          next_state = S_IDLE;
        end else begin
          dat_d      = P_EOF;
          next_state = S_WTRM;
        end
      end
      S_WTRM: begin
        dat_d = P_WTRM;
        if (rx_r_err || rx_sync) begin
          err_d      = 1'b1;
          next_state = S_IDLE;
        end else if (rx_r_ok) begin
          ok_d       = 1'b1;
          next_state = S_IDLE;
        end else if (!phy_rdy || wtrm_timeout) begin
          err_d      = 1'b1;
          next_state = S_IDLE;
        end
      end
      S_DRAIN: begin
        rdreq = ~fifo_empty;
        if (!fifo_empty && fifo_eop) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      link_dat <= P_SYNC;
      link_isk <= 1'b1;
      tx_ok    <= 1'b0;
      tx_err   <= 1'b0;
    end else begin
      state    <= next_state;
      link_dat <= dat_d;
      link_isk <= isk_d;
      tx_ok    <= ok_d;
      tx_err   <= err_d;
    end
  end

`ifdef SATA_LINK_TX_FRAMER_TIMEOUT_EN
  localparam logic [15:0] WTRM_LAST = 16'(WTRM_TIMEOUT - 1);
  logic [15:0] wtrm_cnt;

  always_ff @(posedge clk) begin
    if (!reset) wtrm_cnt <= '0;
    else if (state != S_WTRM) wtrm_cnt <= '0;
    else wtrm_cnt <= wtrm_cnt + 16'd1;
  end

  assign wtrm_timeout = (state == S_WTRM) && (wtrm_cnt == WTRM_LAST);
`else
  assign wtrm_timeout = 1'b0;
`endif

  // Held in reset the framer must not consume FIFO words it is about to forget.
  assign fifo_rdreq = rdreq & reset;
  assign tx_busy    = (state != S_IDLE);

endmodule
